// File: rtl/pong_ball_ctrl.sv
// Pong ball controller: moves the ball once per frame, bounces it off walls
// and paddles, keeps score and sequences serve / point hold / game over.
module pong_ball_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int SPEED       = 2,
    parameter int PADDLE_L_X  = 16,
    parameter int PADDLE_R_X  = 616,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_FRAMES = 60
) (
    input  logic       pixel_clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       in_play,
    output logic       hit,
    output logic       game_over
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [10:0] W11   = 11'(SCREEN_W);
    localparam logic [10:0] H11   = 11'(SCREEN_H);
    localparam logic [10:0] B11   = 11'(BALL_SIZE);
    localparam logic [10:0] S11   = 11'(SPEED);
    localparam logic [10:0] PH11  = 11'(PADDLE_H);
    localparam logic [10:0] LFACE = 11'(PADDLE_L_X + PADDLE_W);
    localparam logic [10:0] RFACE = 11'(PADDLE_R_X);
    localparam logic [10:0] YMAX  = 11'(SCREEN_H - BALL_SIZE);

    localparam logic [9:0] CX = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0] CY = 10'((SCREEN_H - BALL_SIZE) / 2);

    localparam logic [3:0]    WIN4 = 4'(WIN_SCORE);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2,
        OVER   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [3:0]    sl_q, sl_d;
    logic [3:0]    sr_q, sr_d;
    logic          dir_x_q, dir_x_d;
    logic          dir_y_q, dir_y_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          hit_q, hit_d;
    logic          in_play_q;
    logic          game_over_q;

    logic [10:0] bx, by, pl, pr;
    logic        ovl_l, ovl_r;
    logic        l_bounce, r_bounce, l_miss, r_miss;

    // Paddle overlap uses the pre-move row of the ball
    always_comb begin
        bx = {1'b0, x_q};
        by = {1'b0, y_q};
        pl = {1'b0, paddle_l_y};
        pr = {1'b0, paddle_r_y};
        ovl_l = (by + B11 > pl) && (by < pl + PH11);
        ovl_r = (by + B11 > pr) && (by < pr + PH11);
        l_bounce = !dir_x_q && (bx <= LFACE + S11) && (bx >= LFACE) && ovl_l;
        r_bounce = dir_x_q && (bx + B11 + S11 >= RFACE)
                   && (bx + B11 <= RFACE) && ovl_r;
        l_miss = !dir_x_q && (bx <= S11);
        r_miss = dir_x_q && (bx + B11 + S11 >= W11);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sl_d    = sl_q;
        sr_d    = sr_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        hold_d  = hold_q;
        hit_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                x_d = CX;
                y_d = CY;
                if (serve) begin
                    state_d = PLAY;
                end
            end

            PLAY: begin
                if (frame_tick) begin
                    if (dir_y_q) begin
                        if (by + S11 >= YMAX) begin
                            y_d     = YMAX[9:0];
                            dir_y_d = 1'b0;
                        end else begin
                            y_d = 10'(by + S11);
                        end
                    end else begin
                        if (by <= S11) begin
                            y_d     = 10'd0;
                            dir_y_d = 1'b1;
                        end else begin
                            y_d = 10'(by - S11);
                        end
                    end

                    // Paddle faces win over the miss zones behind them
                    if (l_bounce) begin
                        x_d     = LFACE[9:0];
                        dir_x_d = 1'b1;
                        hit_d   = 1'b1;
                    end else if (r_bounce) begin
                        x_d     = 10'(RFACE - B11);
                        dir_x_d = 1'b0;
                        hit_d   = 1'b1;
                    end else if (l_miss) begin
                        sr_d    = sr_q + 4'd1;
                        dir_x_d = 1'b0;
                        hold_d  = '0;
                        state_d = (sr_q + 4'd1 == WIN4) ? OVER : SCORED;
                    end else if (r_miss) begin
                        sl_d    = sl_q + 4'd1;
                        dir_x_d = 1'b1;
                        hold_d  = '0;
                        state_d = (sl_q + 4'd1 == WIN4) ? OVER : SCORED;
                    end else if (dir_x_q) begin
                        x_d = 10'(bx + S11);
                    end else begin
                        x_d = 10'(bx - S11);
                    end
                end
            end

            SCORED: begin
                if (frame_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        x_d     = CX;
                        y_d     = CY;
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end

            OVER: begin
                if (serve) begin
                    sl_d    = 4'd0;
                    sr_d    = 4'd0;
                    x_d     = CX;
                    y_d     = CY;
                    dir_y_d = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= CX;
            y_q         <= CY;
            sl_q        <= 4'd0;
            sr_q        <= 4'd0;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            hold_q      <= '0;
            hit_q       <= 1'b0;
            in_play_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sl_q        <= sl_d;
            sr_q        <= sr_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            hold_q      <= hold_d;
            hit_q       <= hit_d;
            in_play_q   <= (state_d == PLAY);
            game_over_q <= (state_d == OVER);
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign score_l   = sl_q;
    assign score_r   = sr_q;
    assign in_play   = in_play_q;
    assign hit       = hit_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Random-play bench for pong_ball_ctrl against an integer game model.
module tb_pong_ball_ctrl;

    localparam int W = 640, H = 480, B = 8, S = 2;
    localparam int PLX = 16, PRX = 616, PW = 8, PH = 64;
    localparam int WIN = 7, HOLD = 60;
    localparam int CXI = (W - B) / 2, CYI = (H - B) / 2;
    localparam int M_IDLE = 0, M_PLAY = 1, M_SCORED = 2, M_OVER = 3;

    logic       pixel_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] paddle_l_y = '0;
    logic [9:0] paddle_r_y = '0;
    logic [9:0] ball_x, ball_y;
    logic [3:0] score_l, score_r;
    logic       in_play, hit, game_over;

    int checks = 0;
    int failures = 0;

    int mx, my, mdx, mdy, msl, msr, mst, mhold, mhit;
    int dut_hits = 0, m_hits = 0;

    pong_ball_ctrl dut (
        .pixel_clk (pixel_clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .serve     (serve),
        .paddle_l_y(paddle_l_y),
        .paddle_r_y(paddle_r_y),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .score_l   (score_l),
        .score_r   (score_r),
        .in_play   (in_play),
        .hit       (hit),
        .game_over (game_over)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        mst = M_IDLE; mx = CXI; my = CYI;
        msl = 0; msr = 0; mdx = 1; mdy = 1; mhold = 0; mhit = 0;
    endfunction

    function automatic void score_point(input bit right_player);
        if (right_player) msr++; else msl++;
        mdx = right_player ? 0 : 1;
        mhold = 0;
        mst = (msl == WIN || msr == WIN) ? M_OVER : M_SCORED;
    endfunction

    // One clock edge of the game rules, in plain integer arithmetic
    function automatic void model_step(input bit rst, input bit s,
                                       input bit t, input int pl,
                                       input int pr);
        int oy, ny, nx;
        bit ovl_l, ovl_r;
        if (!rst) begin
            model_reset();
            return;
        end
        mhit = 0;
        case (mst)
            M_IDLE: begin
                mx = CXI; my = CYI;
                if (s) mst = M_PLAY;
            end
            M_PLAY: if (t) begin
                oy = my;
                if (mdy == 1) begin
                    if (oy + S >= H - B) begin ny = H - B; mdy = 0; end
                    else ny = oy + S;
                end else begin
                    if (oy <= S) begin ny = 0; mdy = 1; end
                    else ny = oy - S;
                end
                ovl_l = (oy + B > pl) && (oy < pl + PH);
                ovl_r = (oy + B > pr) && (oy < pr + PH);
                nx = mx;
                if (mdx == 0 && mx - S <= PLX + PW && mx >= PLX + PW
                    && ovl_l) begin
                    nx = PLX + PW; mdx = 1; mhit = 1;
                end else if (mdx == 1 && mx + B + S >= PRX
                             && mx + B <= PRX && ovl_r) begin
                    nx = PRX - B; mdx = 0; mhit = 1;
                end else if (mdx == 0 && mx <= S) begin
                    score_point(1);
                end else if (mdx == 1 && mx + B + S >= W) begin
                    score_point(0);
                end else begin
                    nx = (mdx == 1) ? mx + S : mx - S;
                end
                mx = nx; my = ny;
            end
            M_SCORED: if (t) begin
                mhold++;
                if (mhold == HOLD) begin
                    mhold = 0; mx = CXI; my = CYI; mst = M_IDLE;
                end
            end
            default: if (s) begin
                msl = 0; msr = 0; mx = CXI; my = CYI; mdy = 1;
                mst = M_IDLE;
            end
        endcase
    endfunction

    function automatic logic [30:0] model_outs();
        return {10'(mx), 10'(my), 4'(msl), 4'(msr),
                mst == M_PLAY, mhit[0], mst == M_OVER};
    endfunction

    task automatic cycle(input bit r, input bit s, input bit t);
        int pl, pr;
        rst_n = r; serve = s; frame_tick = t;
        pl = int'(paddle_l_y); pr = int'(paddle_r_y);
        @(posedge pixel_clk);
        #1;
        model_step(r, s, t, pl, pr);
        chk("outs", {ball_x, ball_y, score_l, score_r, in_play, hit,
                     game_over}, model_outs());
        if (hit) dut_hits++;
        if (mhit == 1) m_hits++;
    endtask

    function automatic logic [9:0] track(input int y);
        int v;
        v = y - int'($urandom_range(0, 127));
        return (v < 0) ? 10'd0 : 10'(v);
    endfunction

    task automatic rand_cycle();
        if ($urandom_range(0, 3) == 0) begin
            paddle_l_y = track(my);
            paddle_r_y = track(my);
        end
        cycle(1'b1, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, ball_x, 10'd316);
        chk({tag, "_y"}, ball_y, 10'd236);
        chk({tag, "_scores"}, {score_l, score_r}, 8'h00);
        chk({tag, "_flags"}, {in_play, hit, game_over}, 3'b000);
    endtask

    initial begin
        int n;
        paddle_l_y = 10'd100;
        paddle_r_y = 10'd200;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        chk_reset_vals("reset");

        // Serve and frame tick together: no movement yet
        cycle(1'b1, 1'b1, 1'b1);
        chk("serve_play", in_play, 1'b1);
        chk("serve_pos", {ball_x, ball_y}, {10'd316, 10'd236});
        cycle(1'b1, 1'b0, 1'b1);
        chk("first_move", {ball_x, ball_y}, {10'd318, 10'd238});

        n = 0;
        while (mst != M_OVER && n < 60000) begin
            rand_cycle();
            n++;
        end
        chk("game_timeout", n < 60000, 1'b1);
        chk("over_flag", game_over, 1'b1);
        chk("win_score", (score_l == 4'd7) || (score_r == 4'd7), 1'b1);
        chk("hit_count", 32'(dut_hits), 32'(m_hits));
        chk("hits_seen", m_hits > 0, 1'b1);

        cycle(1'b1, 1'b0, 1'b1);
        chk("over_hold", game_over, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        chk("restart_scores", {score_l, score_r}, 8'h00);
        chk("restart_flags", {in_play, game_over}, 2'b00);
        chk("restart_pos", {ball_x, ball_y}, {10'd316, 10'd236});

        cycle(1'b1, 1'b1, 1'b0);
        n = 0;
        while (mst != M_SCORED && n < 20000) begin
            rand_cycle();
            n++;
        end
        chk("point_timeout", n < 20000, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk_reset_vals("mid_hold_reset");
        cycle(1'b1, 1'b0, 1'b1);
        chk("idle_after_reset", in_play, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
